intra_mode_scheduler: RTL
=========================

Name: intra_mode_scheduler

Overview:
- Per-4x4-block controller for the intra prediction datapath.
- Waits for the fetch stage to present a loaded block, then pulses start to the four predictors (DC, Horizontal, Vertical, Plane).
- Derives top/left neighbour availability from block position and collects done flags and SAD costs from the predictors that are available.
- Selects the minimum-cost mode, holds `residual_ready` until the DCT stage acknowledges, and tracks block position across a 424x240 frame.

Parameters:
- COST_W, 16, width of each predictor SAD cost.
- MB_COLS, 106, 4x4 blocks per row (424/4).
- MB_ROWS, 60, 4x4 block rows per frame (240/4).
- TIMEOUT, 255, maximum cycles in COLLECT before forced DC fallback.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  single-cycle pulse; begins a new frame
- blk_valid  in  1  fetch stage has a complete 4x4 block latched
- blk_ack  out  1  single-cycle pulse; block consumed, fetch may load the next block
- pred_start  out  1  single-cycle pulse to all four predictors
- top_avail  out  1  block row > 0
- left_avail  out  1  block column > 0
- pred_done  in  4  per-predictor done: [0] DC, [1] H, [2] V, [3] Plane
- cost_dc, cost_h, cost_v, cost_p  in  COST_W each  SAD cost, valid when the matching done bit is set
- mode  out  2  00 DC, 01 Horizontal, 10 Vertical, 11 Plane
- residual_ready  out  1  mode is valid; residual may be consumed by DCT
- DCT_clear  in  1  DCT has taken the residual
- blk_col  out  7  current block column
- blk_row  out  6  current block row
- frame_done  out  1  single-cycle pulse after the last block is cleared
- timeout_err  out  1  sticky; set on any COLLECT timeout, cleared by reset or frame_start

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0: mode=00, blk_col=0, blk_row=0.
  - Done mask, cost latches and timeout counter cleared.
  - Reset in any state aborts the current block immediately; no pulses are issued afterwards.
- Availability:
  - top_avail = (blk_row != 0); left_avail = (blk_col != 0). Both are combinational from the counters.
  - Required mask: DC always; H needs left; V needs top; Plane needs both.
- IDLE:
  - frame_start -> clear counters and timeout_err, go to WAIT_BLK.
  - frame_start in any state other than IDLE is ignored.
- WAIT_BLK: blk_valid=1 -> START.
- START (exactly one cycle):
  - pred_start=1 and blk_ack=1.
  - Clear done mask and timeout counter.
  - Go to COLLECT.
- COLLECT:
  - Each cycle, OR pred_done into the sticky done mask.
  - On a rising done bit, latch the matching cost.
  - pred_done bits for unavailable modes are ignored.
  - (done mask & required) == required -> DECIDE. This may happen in the same cycle as the last done bit arrives.
  - Timeout counter increments each cycle. Reaching TIMEOUT -> force mode=00, set timeout_err, go to OUTPUT (DECIDE is skipped).
- DECIDE (one cycle):
  - mode <= argmin of latched costs over available modes only.
  - Costs are compared unsigned at COST_W.
  - Ties go to the lower mode code (DC > H > V > Plane priority).
  - Go to OUTPUT.
- OUTPUT:
  - residual_ready=1; mode is stable while residual_ready is high.
  - DCT_clear=1 -> residual_ready=0 next cycle, and advance position:
    - blk_col increments; at MB_COLS-1 it wraps to 0 and blk_row increments.
    - If the block was (MB_COLS-1, MB_ROWS-1): pulse frame_done, reset counters to 0, go to IDLE.
    - Otherwise go to WAIT_BLK.
  - DCT_clear outside OUTPUT is ignored.
- Latency:
  - blk_valid to pred_start: 1 cycle.
  - Final required done to residual_ready: 2 cycles (COLLECT exit, DECIDE).
- Throughput: one block in flight. blk_valid held high during OUTPUT is not acknowledged until the scheduler returns to WAIT_BLK.

Test Plan:
- Block (0,0), frame_start then blk_valid; pred_done=0001, cost_dc=100, all other inputs garbage:
  - pred_start and blk_ack are a 1-cycle pulse 1 cycle after blk_valid.
  - mode=00; residual_ready rises 2 cycles after done.
- Interior block (col 5, row 3); costs dc=50, h=20, v=20, p=30, all done:
  - mode=01 (tie resolved to H).
  - residual_ready held until DCT_clear; then blk_col=6.
- Top-row block (col 4, row 0); cost_v=0 and cost_p=0 supplied, done=1111, dc=40, h=35:
  - V and P are ignored; mode=01; top_avail=0, left_avail=1.
- MB_COLS=2, MB_ROWS=2; four blocks processed:
  - Column wraps after block 2 (row becomes 1).
  - frame_done pulses exactly once, one cycle after the 4th DCT_clear; state returns to IDLE.
  - A 5th blk_valid is not acknowledged.
- TIMEOUT=8; interior block with only DC and H done:
  - After 8 COLLECT cycles: mode=00, timeout_err=1, residual_ready=1.
  - A later frame_start clears timeout_err.
- Reset asserted mid-COLLECT:
  - Next cycle all outputs are 0 and state is IDLE.
  - pred_done pulses arriving afterwards cause no residual_ready.

Source files
------------

// File: rtl/intra_mode_scheduler.sv
// Per-4x4-block intra prediction scheduler: launches the four predictors, collects
// their SAD costs, picks the cheapest available mode and walks the block grid of a frame.
module intra_mode_scheduler #(
    parameter int unsigned COST_W  = 16,
    parameter int unsigned MB_COLS = 106,
    parameter int unsigned MB_ROWS = 60,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              blk_valid,
    output logic              blk_ack,
    output logic              pred_start,
    output logic              top_avail,
    output logic              left_avail,
    input  logic [3:0]        pred_done,
    input  logic [COST_W-1:0] cost_dc,
    input  logic [COST_W-1:0] cost_h,
    input  logic [COST_W-1:0] cost_v,
    input  logic [COST_W-1:0] cost_p,
    output logic [1:0]        mode,
    output logic              residual_ready,
    input  logic              DCT_clear,
    output logic [6:0]        blk_col,
    output logic [5:0]        blk_row,
    output logic              frame_done,
    output logic              timeout_err
);

    localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_BLK = 3'd1,
        START    = 3'd2,
        COLLECT  = 3'd3,
        DECIDE   = 3'd4,
        OUTPUT   = 3'd5
    } state_t;

    state_t             r_state;
    logic [6:0]         r_col;
    logic [5:0]         r_row;
    logic [3:0]         r_mask;
    logic [TMO_W-1:0]   r_tmo;
    logic [COST_W-1:0]  r_cost_dc;
    logic [COST_W-1:0]  r_cost_h;
    logic [COST_W-1:0]  r_cost_v;
    logic [COST_W-1:0]  r_cost_p;
    logic [1:0]         r_mode;
    logic               r_rr;
    logic               r_pred_start;
    logic               r_blk_ack;
    logic               r_frame_done;
    logic               r_tmo_err;

    logic               w_top;
    logic               w_left;
    logic [3:0]         w_req;
    logic [3:0]         w_done_in;
    logic [3:0]         w_mask_nxt;
    logic [3:0]         w_rise;
    logic               w_all_done;
    logic               w_tmo_hit;
    logic               w_last_col;
    logic               w_last_row;
    logic [1:0]         w_best_mode;
    logic [COST_W-1:0]  w_best_cost;

    // Neighbour availability and the set of predictors that must report
    assign w_top      = (r_row != 6'd0);
    assign w_left     = (r_col != 7'd0);
    assign w_req      = {w_top & w_left, w_top, w_left, 1'b1};
    assign w_done_in  = pred_done & w_req;
    assign w_mask_nxt = r_mask | w_done_in;
    assign w_rise     = w_done_in & ~r_mask;
    assign w_all_done = ((w_mask_nxt & w_req) == w_req);
    assign w_tmo_hit  = (r_tmo == TMO_W'(TIMEOUT - 1));
    assign w_last_col = (r_col == 7'(MB_COLS - 1));
    assign w_last_row = (r_row == 6'(MB_ROWS - 1));

    // Strict less-than keeps ties on the lower mode code
    always_comb begin
        w_best_mode = 2'd0;
        w_best_cost = r_cost_dc;
        if (w_req[1] && (r_cost_h < w_best_cost)) begin
            w_best_mode = 2'd1;
            w_best_cost = r_cost_h;
        end
        if (w_req[2] && (r_cost_v < w_best_cost)) begin
            w_best_mode = 2'd2;
            w_best_cost = r_cost_v;
        end
        if (w_req[3] && (r_cost_p < w_best_cost)) begin
            w_best_mode = 2'd3;
            w_best_cost = r_cost_p;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_col        <= 7'd0;
            r_row        <= 6'd0;
            r_mask       <= 4'd0;
            r_tmo        <= TMO_W'(0);
            r_cost_dc    <= COST_W'(0);
            r_cost_h     <= COST_W'(0);
            r_cost_v     <= COST_W'(0);
            r_cost_p     <= COST_W'(0);
            r_mode       <= 2'd0;
            r_rr         <= 1'b0;
            r_pred_start <= 1'b0;
            r_blk_ack    <= 1'b0;
            r_frame_done <= 1'b0;
            r_tmo_err    <= 1'b0;
        end else begin
            r_pred_start <= 1'b0;
            r_blk_ack    <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (frame_start) begin
                        r_col     <= 7'd0;
                        r_row     <= 6'd0;
                        r_tmo_err <= 1'b0;
                        r_state   <= WAIT_BLK;
                    end
                end
                WAIT_BLK: begin
                    if (blk_valid) begin
                        r_pred_start <= 1'b1;
                        r_blk_ack    <= 1'b1;
                        r_state      <= START;
                    end
                end
                START: begin
                    r_mask  <= 4'd0;
                    r_tmo   <= TMO_W'(0);
                    r_state <= COLLECT;
                end
                COLLECT: begin
                    r_mask <= w_mask_nxt;
                    if (w_rise[0]) r_cost_dc <= cost_dc;
                    if (w_rise[1]) r_cost_h  <= cost_h;
                    if (w_rise[2]) r_cost_v  <= cost_v;
                    if (w_rise[3]) r_cost_p  <= cost_p;
                    if (w_all_done) begin
                        r_state <= DECIDE;
                    end else if (w_tmo_hit) begin
                        // Stalled predictor: fall back to DC without a decision
                        r_mode    <= 2'd0;
                        r_tmo_err <= 1'b1;
                        r_rr      <= 1'b1;
                        r_state   <= OUTPUT;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                DECIDE: begin
                    r_mode  <= w_best_mode;
                    r_rr    <= 1'b1;
                    r_state <= OUTPUT;
                end
                OUTPUT: begin
                    if (DCT_clear) begin
                        r_rr <= 1'b0;
                        if (w_last_col) begin
                            r_col <= 7'd0;
                            if (w_last_row) begin
                                r_row        <= 6'd0;
                                r_frame_done <= 1'b1;
                                r_state      <= IDLE;
                            end else begin
                                r_row   <= r_row + 6'd1;
                                r_state <= WAIT_BLK;
                            end
                        end else begin
                            r_col   <= r_col + 7'd1;
                            r_state <= WAIT_BLK;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign blk_ack        = r_blk_ack;
    assign pred_start     = r_pred_start;
    assign top_avail      = w_top;
    assign left_avail     = w_left;
    assign mode           = r_mode;
    assign residual_ready = r_rr;
    assign blk_col        = r_col;
    assign blk_row        = r_row;
    assign frame_done     = r_frame_done;
    assign timeout_err    = r_tmo_err;

endmodule
